health_ctrl: RTL and testbench
==============================

// Module: health_ctrl
// PURPOSE
//  Lives/health sequencer for the heart HUD. Takes game commands written by the
//  CPU over the APB slave (START/HIT/HEAL), keeps the lives count, and runs the
//  post-hit invulnerability blink. Drives the per-slot heart-enable mask that
//  gates the heart sprite renderers.
//  All state changes are frame-synchronous, taken on the animate tick, so the
//  HUD never tears mid-frame.
// PARAMETERS
//  MAX_LIVES     3  lives after START and number of heart slots (1..7)
//  BLINK_FRAMES  8  animate ticks per blink half-period
//  BLINK_TOGGLES 6  blink phase toggles before leaving BLINK (must be even)
// PORTS
//  clk         in   1          system clock
//  res         in   1          asynchronous reset, active-low
//  write_en0   in   1          APB write strobe
//  right_addr  in   1          APB address decode hit for this block
//  pwdata      in   32         APB write data; [1:0]=cmd, [31:2] ignored
//  animate     in   1          one-clk pulse per video frame
//  lives       out  3          current lives, 0..MAX_LIVES
//  heart_on    out  MAX_LIVES  bit i enables heart slot i
//  blinking    out  1          high while in BLINK state
//  game_over   out  1          high while in DEAD state
// BEHAVIOUR
//  Reset (res=0, async): state=IDLE; lives, heart_on, blinking, game_over,
//   pending flags, frame_cnt, toggle_cnt and phase are all 0.
//  Command capture: on a clk edge with write_en0&right_addr, decode cmd:
//   00 nop, 01 START, 10 HIT, 11 HEAL. Set pend_start, pend_hit or pend_heal.
//   Several writes within one frame OR into the flags; each command acts at
//   most once per frame.
//  Frame processing: on a clk edge with animate=1, evaluate the FSM from the
//   pending flags, then clear the flags. Priority is START > HIT > HEAL.
//   A write in the same cycle as animate is not used this tick; its flag is set
//   after the clear and is processed on the next animate.
//  FSM (all transitions only on animate):
//   IDLE : START -> ALIVE, lives=MAX_LIVES. HIT and HEAL are ignored.
//   ALIVE: START -> lives=MAX_LIVES.
//          HIT and lives==1 -> DEAD, lives=0.
//          HIT and lives>1 -> BLINK, lives-=1, frame_cnt=0, toggle_cnt=0, phase=0.
//          HEAL -> lives=min(lives+1, MAX_LIVES).
//   BLINK: START -> ALIVE, lives=MAX_LIVES, blink counters cleared.
//          HIT is ignored (invulnerable). HEAL is applied with saturation.
//          Each tick frame_cnt++. At frame_cnt==BLINK_FRAMES-1: frame_cnt=0,
//          phase toggles, toggle_cnt++.
//          When toggle_cnt reaches BLINK_TOGGLES -> ALIVE.
//          BLINK therefore lasts BLINK_FRAMES*BLINK_TOGGLES ticks.
//   DEAD : game_over=1. Only START leaves, going to ALIVE with
//          lives=MAX_LIVES. HIT and HEAL are ignored.
//  heart_on: registered on the animate edge from the next-state values.
//   Bit i = (i < lives). In BLINK, bit[lives] (the slot just lost) = phase.
//   In IDLE/DEAD the mask is all 0.
//   A HEAL in BLINK that raises lives makes bit[lives_new] the blinking bit.
//   If lives_new==MAX_LIVES, no bit blinks.
//  blinking/game_over: registered and updated on the same edge as state.
//  Widths: lives is 3b unsigned; decrement never goes below 0 and increment
//   saturates at MAX_LIVES. frame_cnt and toggle_cnt are sized by clog2 of
//   their parameters.
//  Outputs change only on animate edges or on reset. No output depends
//   combinationally on any input.
// TESTING
//  T1 reset, write 0x1, animate -> next clk lives=3, heart_on=3'b111, blinking=0
//  T2 from T1 write 0x2, animate -> lives=2, blinking=1, heart_on=3'b011.
//     Bit2 toggles every 8 ticks. After 48 ticks blinking=0, heart_on=3'b011.
//  T3 in BLINK write 0x2, animate -> lives stays 2.
//     Write 0x3 in BLINK -> lives=3, heart_on=3'b111, still blinking.
//  T4 three spaced HITs from lives=3 -> lives=0, game_over=1, heart_on=0.
//     HIT/HEAL in DEAD have no effect. START -> lives=3, game_over=0.
//  T5 write 0x1 and 0x2 in one frame -> START wins, lives=3, no blink.
//     Write coincident with animate -> acts on the following tick.
//  T6 assert res=0 mid-BLINK (asynchronously, between clk edges)
//     -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/health_ctrl.sv
// health_ctrl: APB-driven lives/invulnerability sequencer producing the heart HUD slot mask
module health_ctrl #(
   parameter int MAX_LIVES     = 3,
   parameter int BLINK_FRAMES  = 8,
   parameter int BLINK_TOGGLES = 6
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 write_en0,
   input  logic                 right_addr,
   input  logic [31:0]          pwdata,
   input  logic                 animate,
   output logic [2:0]           lives,
   output logic [MAX_LIVES-1:0] heart_on,
   output logic                 blinking,
   output logic                 game_over
);
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam int TW = BLINK_TOGGLES > 1 ? $clog2(BLINK_TOGGLES) : 1;
   localparam logic [2:0]    ML = 3'(MAX_LIVES);
   localparam logic [FW-1:0] FL = FW'(BLINK_FRAMES - 1);
   localparam logic [TW-1:0] TL = TW'(BLINK_TOGGLES - 1);
   typedef enum logic [1:0] {IDLE, ALIVE, BLINK, DEAD} state_t;
   state_t state, state_n;
   logic [2:0] lives_n, lives_inc;
   logic [FW-1:0] frame_cnt, fc_n;
   logic [TW-1:0] toggle_cnt, tc_n;
   logic phase, ph_n;
   logic pend_start, pend_hit, pend_heal;
   logic [MAX_LIVES-1:0] heart_n;
   logic wr;
   logic unused_pw;
   assign wr        = write_en0 & right_addr;
   assign unused_pw = ^pwdata[31:2];
   assign lives_inc = lives >= ML ? ML : lives + 3'd1;
   assign blinking  = state == BLINK;
   assign game_over = state == DEAD;
   always_comb begin
      state_n = state;
      lives_n = lives;
      fc_n    = frame_cnt;
      tc_n    = toggle_cnt;
      ph_n    = phase;
      case (state)
         IDLE: if (pend_start) begin
            state_n = ALIVE;
            lives_n = ML;
         end
         ALIVE: if (pend_start) lives_n = ML;
         else if (pend_hit) begin
            state_n = lives <= 3'd1 ? DEAD : BLINK;
            lives_n = lives <= 3'd1 ? 3'd0 : lives - 3'd1;
            fc_n    = '0;
            tc_n    = '0;
            ph_n    = 1'b0;
         end else if (pend_heal) lives_n = lives_inc;
         BLINK: if (pend_start) begin
            state_n = ALIVE;
            lives_n = ML;
            fc_n    = '0;
            tc_n    = '0;
            ph_n    = 1'b0;
         end else begin
            if (pend_heal) lives_n = lives_inc;
            fc_n = frame_cnt + 1'b1;
            if (frame_cnt == FL) begin
               fc_n = '0;
               ph_n = ~phase;
               tc_n = toggle_cnt + 1'b1;
               if (toggle_cnt == TL) begin
                  state_n = ALIVE;
                  tc_n    = '0;
                  ph_n    = 1'b0;
               end
            end
         end
         default: if (pend_start) begin
            state_n = ALIVE;
            lives_n = ML;
         end
      endcase
   end
   // the slot just lost (index == lives) carries the blink phase
   always_comb begin
      heart_n = '0;
      for (int i = 0; i < MAX_LIVES; i++)
         heart_n[i] = (state_n == ALIVE || state_n == BLINK) &&
                      (3'(i) < lives_n || (state_n == BLINK && 3'(i) == lives_n && ph_n));
   end
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state      <= IDLE;
         lives      <= '0;
         frame_cnt  <= '0;
         toggle_cnt <= '0;
         phase      <= 1'b0;
         heart_on   <= '0;
         pend_start <= 1'b0;
         pend_hit   <= 1'b0;
         pend_heal  <= 1'b0;
      end else begin
         pend_start <= (pend_start & ~animate) | (wr && pwdata[1:0] == 2'b01);
         pend_hit   <= (pend_hit   & ~animate) | (wr && pwdata[1:0] == 2'b10);
         pend_heal  <= (pend_heal  & ~animate) | (wr && pwdata[1:0] == 2'b11);
         if (animate) begin
            state      <= state_n;
            lives      <= lives_n;
            frame_cnt  <= fc_n;
            toggle_cnt <= tc_n;
            phase      <= ph_n;
            heart_on   <= heart_n;
         end
      end
   end
endmodule

// File: tb/tb_health_ctrl.sv
// tb_health_ctrl: directed self-checking bench for health_ctrl
module tb_health_ctrl;
   logic clk = 1'b0;
   logic res = 1'b0;
   logic write_en0 = 1'b0;
   logic right_addr = 1'b0;
   logic [31:0] pwdata = '0;
   logic animate = 1'b0;
   logic [2:0] lives;
   logic [2:0] heart_on;
   logic blinking, game_over;
   int n_tests = 0;
   int n_fail = 0;

   health_ctrl #(.MAX_LIVES(3), .BLINK_FRAMES(8), .BLINK_TOGGLES(6)) dut (
      .clk(clk), .res(res), .write_en0(write_en0), .right_addr(right_addr),
      .pwdata(pwdata), .animate(animate), .lives(lives), .heart_on(heart_on),
      .blinking(blinking), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int l, input int h, input int b, input int g);
      check({tag, ".lives"}, 32'(lives), 32'(l));
      check({tag, ".heart"}, 32'(heart_on), 32'(h));
      check({tag, ".blink"}, 32'(blinking), 32'(b));
      check({tag, ".over"}, 32'(game_over), 32'(g));
   endtask

   task automatic write(input logic [1:0] c, input logic hit = 1'b1);
      @(negedge clk);
      write_en0 = 1'b1; right_addr = hit; pwdata = {30'h15555555, c};
      @(negedge clk);
      write_en0 = 1'b0; right_addr = 1'b0; pwdata = '0;
   endtask

   task automatic tick();
      @(negedge clk);
      animate = 1'b1;
      @(negedge clk);
      animate = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_out("reset", 0, 0, 0, 0);
      res = 1'b1;
      // IDLE ignores HIT
      write(2'b10); tick();
      chk_out("idle_hit", 0, 0, 0, 0);
      // T1
      write(2'b01);
      check("no_tick_yet", 32'(lives), 0);
      tick();
      chk_out("t1_start", 3, 3'b111, 0, 0);
      // T2: hit then 48-tick blink
      write(2'b10); tick();
      chk_out("t2_hit", 2, 3'b011, 1, 0);
      for (int k = 1; k <= 48; k++) begin
         tick();
         check($sformatf("t2_heart%0d", k), 32'(heart_on), (k < 48 && ((k / 8) % 2 == 1)) ? 32'h7 : 32'h3);
         check($sformatf("t2_blink%0d", k), 32'(blinking), k < 48 ? 32'h1 : 32'h0);
      end
      check("t2_lives", 32'(lives), 2);
      // non-decoded address ignored
      write(2'b10, 1'b0); tick();
      chk_out("bad_addr", 2, 3'b011, 0, 0);
      // heal in ALIVE, then saturation
      write(2'b11); tick();
      chk_out("heal", 3, 3'b111, 0, 0);
      write(2'b11); tick();
      check("heal_sat", 32'(lives), 3);
      // T3
      write(2'b10); tick();
      chk_out("t3_hit", 2, 3'b011, 1, 0);
      write(2'b10); tick();
      chk_out("t3_invuln", 2, 3'b011, 1, 0);
      write(2'b11); tick();
      chk_out("t3_heal", 3, 3'b111, 1, 0);
      ticks(45);
      check("t3_still_blink", 32'(blinking), 1);
      tick();
      chk_out("t3_end", 3, 3'b111, 0, 0);
      // T4
      write(2'b10); tick();
      chk_out("t4_hit1", 2, 3'b011, 1, 0);
      ticks(48);
      write(2'b10); tick();
      chk_out("t4_hit2", 1, 3'b001, 1, 0);
      ticks(8);
      check("t4_bit1_on", 32'(heart_on), 3'b011);
      ticks(40);
      chk_out("t4_alive1", 1, 3'b001, 0, 0);
      write(2'b10); tick();
      chk_out("t4_dead", 0, 0, 0, 1);
      write(2'b10); write(2'b11); tick();
      chk_out("t4_dead_ign", 0, 0, 0, 1);
      write(2'b01); tick();
      chk_out("t4_restart", 3, 3'b111, 0, 0);
      // T5
      write(2'b01); write(2'b10); tick();
      chk_out("t5_prio", 3, 3'b111, 0, 0);
      @(negedge clk);
      animate = 1'b1; write_en0 = 1'b1; right_addr = 1'b1; pwdata = 32'h2;
      @(negedge clk);
      animate = 1'b0; write_en0 = 1'b0; right_addr = 1'b0; pwdata = '0;
      chk_out("t5_coinc", 3, 3'b111, 0, 0);
      tick();
      chk_out("t5_next", 2, 3'b011, 1, 0);
      // T6: async reset mid-blink
      ticks(10);
      check("t6_pre", 32'(heart_on), 3'b111);
      @(negedge clk);
      #2 res = 1'b0;
      #1 chk_out("t6_async", 0, 0, 0, 0);
      @(negedge clk);
      res = 1'b1;
      tick();
      chk_out("t6_idle", 0, 0, 0, 0);
      write(2'b01); tick();
      chk_out("t6_start", 3, 3'b111, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
